// File: rtl/stage_memory.sv
// Memory-access stage: range-checks the execute address, runs one load/store per
// instruction on a req/ack bus, and registers the result or an address exception.
module stage_memory #(
  parameter logic [31:0] DM_END       = 32'h0000_3000,
  parameter logic [31:0] TC0_BASE     = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE     = 32'h0000_7F10,
  parameter int          MEM_TYPE_LEN = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [31:0]             alu_result,
  input  logic [31:0]             store_data,
  input  logic [MEM_TYPE_LEN-1:0] mem_type,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic                    load_signed,
  input  logic                    mem_unaligned,
  input  logic                    overflowed,
  input  logic [4:0]              dst_in,
  input  logic                    flush,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [31:0]             bus_addr,
  output logic [3:0]              bus_be,
  output logic [31:0]             bus_wdata,
  input  logic [31:0]             bus_rdata,
  input  logic                    bus_ack,
  output logic                    mem_busy,
  output logic                    wb_valid,
  output logic [31:0]             wb_data,
  output logic [4:0]              wb_dst,
  output logic                    exc_valid,
  output logic [4:0]              exc_code,
  output logic [31:0]             exc_badvaddr
);

  localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_BYTE = MEM_TYPE_LEN'(0);
  localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_HALF = MEM_TYPE_LEN'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  function automatic logic [3:0] align_be(input logic [MEM_TYPE_LEN-1:0] mt,
                                          input logic [1:0] off);
    case (mt)
      MEM_TYPE_BYTE: align_be = 4'b0001 << off;
      MEM_TYPE_HALF: align_be = off[1] ? 4'b1100 : 4'b0011;
      default:       align_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] align_wdata(input logic [MEM_TYPE_LEN-1:0] mt,
                                              input logic [31:0] data);
    case (mt)
      MEM_TYPE_BYTE: align_wdata = {4{data[7:0]}};
      MEM_TYPE_HALF: align_wdata = {2{data[15:0]}};
      default:       align_wdata = data;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [MEM_TYPE_LEN-1:0] mt,
                                              input logic [1:0] off,
                                              input logic sgn,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (mt)
      MEM_TYPE_BYTE: extend_load = {{24{sgn & b[7]}}, b};
      MEM_TYPE_HALF: extend_load = {{16{sgn & h[15]}}, h};
      default:       extend_load = rdata;
    endcase
  endfunction

  logic [1:0]              r_state;
  logic                    r_we;
  logic [31:0]             r_addr;
  logic [1:0]              r_off;
  logic [3:0]              r_be;
  logic [31:0]             r_wdata;
  logic [MEM_TYPE_LEN-1:0] r_mt;
  logic                    r_sgn;
  logic [4:0]              r_dst;
  logic                    r_wb_valid;
  logic [31:0]             r_wb_data;
  logic [4:0]              r_wb_dst;
  logic                    r_exc_valid;
  logic [4:0]              r_exc_code;
  logic [31:0]             r_exc_badvaddr;

  logic w_is_mem, w_in_dm, w_in_tc0, w_in_tc1, w_in_tc, w_tc_count, w_exc;

  // Timer windows are 3 words; offset 8 in each is the read-only count register.
  assign w_is_mem   = in_valid && (mem_read || mem_write);
  assign w_in_dm    = alu_result < DM_END;
  assign w_in_tc0   = (alu_result >= TC0_BASE) && (alu_result < TC0_BASE + 32'd12);
  assign w_in_tc1   = (alu_result >= TC1_BASE) && (alu_result < TC1_BASE + 32'd12);
  assign w_in_tc    = w_in_tc0 || w_in_tc1;
  assign w_tc_count = (w_in_tc0 && (alu_result >= TC0_BASE + 32'd8)) ||
                      (w_in_tc1 && (alu_result >= TC1_BASE + 32'd8));
  assign w_exc      = w_is_mem && (mem_unaligned || overflowed ||
                                   !(w_in_dm || w_in_tc) ||
                                   (w_in_tc && (mem_type != MEM_TYPE_LEN'(2))) ||
                                   (mem_write && w_tc_count));

  assign mem_busy     = (r_state != S_IDLE) || (w_is_mem && !w_exc && !flush);
  assign bus_req      = (r_state != S_IDLE);
  assign bus_we       = r_we;
  assign bus_addr     = r_addr;
  assign bus_be       = r_be;
  assign bus_wdata    = r_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_dst       = r_wb_dst;
  assign exc_valid    = r_exc_valid;
  assign exc_code     = r_exc_code;
  assign exc_badvaddr = r_exc_badvaddr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_off          <= '0;
      r_be           <= '0;
      r_wdata        <= '0;
      r_mt           <= '0;
      r_sgn          <= 1'b0;
      r_dst          <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_data      <= '0;
      r_wb_dst       <= '0;
      r_exc_valid    <= 1'b0;
      r_exc_code     <= '0;
      r_exc_badvaddr <= '0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_exc_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            if (!w_is_mem) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= alu_result;
              r_wb_dst   <= dst_in;
            end else if (w_exc) begin
              r_exc_valid    <= 1'b1;
              r_exc_code     <= mem_write ? 5'd5 : 5'd4;
              r_exc_badvaddr <= alu_result;
            end else begin
              r_we    <= mem_write;
              r_addr  <= {alu_result[31:2], 2'b00};
              r_off   <= alu_result[1:0];
              r_be    <= align_be(mem_type, alu_result[1:0]);
              r_wdata <= align_wdata(mem_type, store_data);
              r_mt    <= mem_type;
              r_sgn   <= load_signed;
              r_dst   <= dst_in;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A flush cannot cancel a bus cycle already issued; it only drops the result.
          if (flush) begin
            r_state <= bus_ack ? S_IDLE : S_DRAIN;
          end else if (bus_ack) begin
            r_state    <= S_IDLE;
            r_wb_valid <= 1'b1;
            r_wb_data  <= r_we ? 32'd0 : extend_load(r_mt, r_off, r_sgn, bus_rdata);
            r_wb_dst   <= r_dst;
          end
        end
        S_DRAIN: begin
          if (bus_ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Randomized and directed bench for stage_memory against a transaction-level model.
module tb_stage_memory;

  localparam logic [1:0] MT_B = 2'd0;
  localparam logic [1:0] MT_H = 2'd1;
  localparam logic [1:0] MT_W = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [1:0]  mem_type;
  logic        mem_read;
  logic        mem_write;
  logic        load_signed;
  logic        mem_unaligned;
  logic        overflowed;
  logic [4:0]  dst_in;
  logic        flush;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        mem_busy;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;

  int total = 0;
  int bad   = 0;

  logic [31:0] edge_addrs [10] = '{32'h2FFC, 32'h3000, 32'h7EFC, 32'h7F08, 32'h7F0C,
                                   32'h7F10, 32'h7F18, 32'h7F1C, 32'h0000, 32'hFFFF_FF00};

  stage_memory dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
    .store_data(store_data), .mem_type(mem_type), .mem_read(mem_read),
    .mem_write(mem_write), .load_signed(load_signed), .mem_unaligned(mem_unaligned),
    .overflowed(overflowed), .dst_in(dst_in), .flush(flush), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .mem_busy(mem_busy),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dst(wb_dst), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_badvaddr(exc_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour of one instruction, derived from the address map and access size.
  task automatic model(input logic [31:0] a, input logic [31:0] sd, input logic [1:0] mt,
                       input bit rd, input bit wr, input bit sgn, input bit ovf, input bit unal,
                       input logic [31:0] rdata,
                       output bit is_mem, output bit exc, output logic [4:0] code,
                       output logic [3:0] be, output logic [31:0] wd, output logic [31:0] res);
    int size, off;
    bit in_dm, in_t0, in_t1, cnt;
    logic [31:0] mask, v;
    size  = (mt == MT_B) ? 1 : (mt == MT_H) ? 2 : 4;
    off   = int'(a % 4) - int'(a % size);
    in_dm = a < 32'h3000;
    in_t0 = (a >= 32'h7F00) && (a < 32'h7F0C);
    in_t1 = (a >= 32'h7F10) && (a < 32'h7F1C);
    cnt   = (in_t0 && a >= 32'h7F08) || (in_t1 && a >= 32'h7F18);
    is_mem = rd || wr;
    exc  = is_mem && (unal || ovf || !(in_dm || in_t0 || in_t1) ||
                      ((in_t0 || in_t1) && size != 4) || (wr && cnt));
    code = wr ? 5'd5 : 5'd4;
    be   = 4'(((1 << size) - 1) << off);
    wd   = (size == 1) ? sd[7:0] * 32'h0101_0101 :
           (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
    v    = (rdata >> (8 * off)) & mask;
    if (sgn && v[8*size-1]) v = v | ~mask;
    res  = wr ? 32'd0 : v;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] sd, input logic [1:0] mt,
                       input bit rd, input bit wr, input bit sgn, input bit ovf, input bit unal,
                       input logic [4:0] dst, input int waits, input logic [31:0] rdata);
    bit is_mem, exc;
    logic [4:0]  code;
    logic [3:0]  be;
    logic [31:0] wd, res;
    model(a, sd, mt, rd, wr, sgn, ovf, unal, rdata, is_mem, exc, code, be, wd, res);
    if (!is_mem) res = a;
    @(negedge clk);
    in_valid = 1'b1; alu_result = a; store_data = sd; mem_type = mt;
    mem_read = rd; mem_write = wr; load_signed = sgn; overflowed = ovf;
    mem_unaligned = unal; dst_in = dst; flush = 1'b0;
    bus_ack = 1'($urandom); bus_rdata = $urandom;
    #1;
    chk("busy_accept", mem_busy, 32'(is_mem && !exc));
    chk("req_idle", bus_req, 0);
    chk("pulse_drop", {wb_valid, exc_valid}, 0);
    if (is_mem && !exc) begin
      for (int c = 0; c <= waits; c++) begin
        @(negedge clk);
        in_valid = 1'b0; alu_result = $urandom; store_data = $urandom;
        mem_type = 2'($urandom % 3); load_signed = 1'($urandom); dst_in = 5'($urandom);
        bus_rdata = rdata; bus_ack = (c == waits);
        #1;
        chk("req", bus_req, 1);
        chk("we", bus_we, 32'(wr));
        chk("addr", bus_addr, a & ~32'd3);
        chk("be", bus_be, be);
        chk("wdata", bus_wdata, wd);
        chk("busy_req", mem_busy, 1);
        chk("wb_early", wb_valid, 0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; bus_ack = 1'($urandom); bus_rdata = $urandom;
    #1;
    chk("wb_valid", wb_valid, 32'(!exc));
    chk("exc_valid", exc_valid, 32'(exc));
    if (exc) begin
      chk("exc_code", exc_code, code);
      chk("badvaddr", exc_badvaddr, a);
    end else begin
      chk("wb_data", wb_data, res);
      chk("wb_dst", wb_dst, dst);
    end
    chk("req_done", bus_req, 0);
    chk("busy_done", mem_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, rd_val;
    int sel, size, kind;
    logic [1:0] mt;

    reset = 1'b1; in_valid = 1'b0; alu_result = '0; store_data = '0; mem_type = MT_W;
    mem_read = 1'b0; mem_write = 1'b0; load_signed = 1'b0; mem_unaligned = 1'b0;
    overflowed = 1'b0; dst_in = '0; flush = 1'b0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctl", {bus_req, bus_we, bus_be, wb_valid, exc_valid, exc_code, mem_busy}, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wbd", wb_data, 0);
    reset = 1'b0;

    // Directed: store byte, signed/unsigned half loads with wait states
    do_op(32'h0000_0102, 32'h1234_56AB, MT_B, 0, 1, 0, 0, 0, 5'd1, 0, 32'h0);
    do_op(32'h0000_0006, 32'h0, MT_H, 1, 0, 1, 0, 0, 5'd2, 3, 32'h8001_7FFF);
    do_op(32'h0000_0006, 32'h0, MT_H, 1, 0, 0, 0, 0, 5'd3, 3, 32'h8001_7FFF);

    // Exceptions
    do_op(32'h0000_3000, 32'h0, MT_W, 1, 0, 0, 0, 0, 5'd4, 0, 32'h0);
    do_op(32'h0000_7F00, 32'h55, MT_B, 0, 1, 0, 0, 0, 5'd5, 0, 32'h0);
    do_op(32'h0000_7F08, 32'h55, MT_W, 0, 1, 0, 0, 0, 5'd6, 0, 32'h0);
    do_op(32'h0000_0040, 32'h0, MT_W, 1, 0, 0, 0, 1, 5'd7, 0, 32'h0);

    // Flush during the second REQ cycle, ack two cycles later
    @(negedge clk);
    in_valid = 1'b1; alu_result = 32'h20; store_data = 32'hCAFE_0001; mem_type = MT_W;
    mem_read = 1'b0; mem_write = 1'b1; load_signed = 1'b0; overflowed = 1'b0;
    mem_unaligned = 1'b0; dst_in = 5'd8; flush = 1'b0; bus_ack = 1'b0;
    #1 chk("fl_busy", mem_busy, 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0; flush = (c == 2); bus_ack = (c == 4);
      #1;
      chk("fl_req", bus_req, 1);
      chk("fl_wb", wb_valid, 0);
      chk("fl_exc", exc_valid, 0);
    end
    do_op(32'h0000_0024, 32'h0, MT_W, 1, 0, 0, 0, 0, 5'd9, 1, 32'h1357_9BDF);

    // Reset asserted mid-REQ
    @(negedge clk);
    in_valid = 1'b1; alu_result = 32'h30; store_data = 32'hFFFF_FFFF; mem_type = MT_W;
    mem_read = 1'b1; mem_write = 1'b0; dst_in = 5'd10; bus_ack = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("rs_req", bus_req, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rs_ctl", {bus_req, bus_we, bus_be, wb_valid, exc_valid, exc_code, mem_busy}, 0);
    chk("rs_addr", bus_addr, 0);
    chk("rs_wdata", bus_wdata, 0);
    chk("rs_wbd", wb_data, 0);
    chk("rs_wbdst", wb_dst, 0);
    chk("rs_bad", exc_badvaddr, 0);
    reset = 1'b0;

    // Back-to-back: ALU, load word, ALU held by mem_busy
    @(negedge clk);
    in_valid = 1'b1; alu_result = 32'h55; mem_read = 1'b0; mem_write = 1'b0;
    overflowed = 1'b0; mem_unaligned = 1'b0; dst_in = 5'd3; bus_ack = 1'b0;
    #1 chk("bb_busy0", mem_busy, 0);
    @(negedge clk);
    alu_result = 32'h10; mem_type = MT_W; mem_read = 1'b1; dst_in = 5'd4;
    #1;
    chk("bb_alu1", wb_valid, 1);
    chk("bb_alu1d", wb_data, 32'h55);
    chk("bb_busy1", mem_busy, 1);
    @(negedge clk);
    alu_result = 32'h77; mem_read = 1'b0; dst_in = 5'd5; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("bb_req", bus_req, 1);
    chk("bb_hold", mem_busy, 1);
    chk("bb_wb2", wb_valid, 0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("bb_ld", wb_valid, 1);
    chk("bb_ldd", wb_data, 32'hDEAD_BEEF);
    chk("bb_lddst", wb_dst, 4);
    chk("bb_busy3", mem_busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bb_alu2", wb_valid, 1);
    chk("bb_alu2d", wb_data, 32'h77);
    chk("bb_alu2dst", wb_dst, 5);

    // Flush in IDLE suppresses the input
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; alu_result = 32'h99; mem_read = 1'b0; mem_write = 1'b0;
    #1 chk("fi_busy0", mem_busy, 0);
    @(negedge clk);
    alu_result = 32'h40; mem_type = MT_W; mem_read = 1'b1;
    #1;
    chk("fi_wb0", wb_valid, 0);
    chk("fi_busy1", mem_busy, 0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("fi_out", {bus_req, wb_valid, exc_valid}, 0);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      sel = $urandom % 8;
      case (sel)
        0, 1, 2, 3: a = $urandom % 32'h3000;
        4:          a = 32'h7F00 + $urandom % 12;
        5:          a = 32'h7F10 + $urandom % 12;
        6:          a = $urandom;
        default:    a = edge_addrs[$urandom % 10];
      endcase
      mt   = 2'($urandom % 3);
      size = (mt == MT_B) ? 1 : (mt == MT_H) ? 2 : 4;
      if ($urandom % 4 != 0) a = a & ~32'(size - 1);
      kind   = $urandom % 3;
      rd_val = $urandom;
      do_op(a, $urandom, mt, kind == 1, kind == 2, 1'($urandom), ($urandom % 16) == 0,
            (a % size) != 0, 5'($urandom), $urandom % 4, rd_val);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
